acc_multi_sequencer: RTL
========================

// Module: acc_multi_sequencer
// PURPOSE
//  Issues the one-hot instruction grant vector to the acc_multi datapath from its decode outputs.
//  Retires LOAD/ADD/STORE/BRZ in one grant cycle.
//  Microsequences STRCPY/STRNCPY as byte read/write loops on a shared req/gnt memory port.
//  Retires a string instruction with a grant pulse only after its last write is accepted.
//  Sits between the ILA-generated datapath and the memory subsystem.
// PARAMETERS
//  ADDR_W       16   memory address width
//  DATA_W       16   memory data width
//  MAX_STR_LEN  256  byte cap per STRCPY; reaching it terminates the copy with err_overrun
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  inst_valid   in   1       datapath decode/operands valid this cycle
//  decode       in   6       one-hot decode [0]LOAD [1]ADD [2]STORE [3]BRZ [4]STRCPY [5]STRNCPY
//  str_src      in   ADDR_W  string source base; sampled at string start
//  str_dst      in   ADDR_W  string destination base; sampled at string start
//  str_len      in   16      STRNCPY byte count; sampled at string start
//  grant        out  6       one-hot grant to datapath; single-cycle pulse
//  busy         out  1       sequencer not in IDLE
//  err_decode   out  1       1-cycle pulse: inst_valid with zero or multi-hot decode
//  err_overrun  out  1       1-cycle pulse, coincident with grant[4], when STRCPY hits MAX_STR_LEN
//  mem_req      out  1       memory request
//  mem_we       out  1       1 = write, 0 = read
//  mem_addr     out  ADDR_W  request address
//  mem_wdata    out  DATA_W  write data: {8'h00, byte}
//  mem_gnt      in   1       request accepted this cycle
//  mem_rvalid   in   1       read data valid; arrives >=1 cycle after accepted read
//  mem_rdata    in   DATA_W  read data; byte = [7:0]
// BEHAVIOUR
//  Reset: the following are 0 and state = IDLE:
//   - outputs grant, busy, err_*, mem_req, mem_we, mem_addr, mem_wdata
//   - internal idx, byte register, latched bases
//  Reset is honoured mid-operation: an outstanding request is dropped and no grant is issued.
//  FSM: IDLE, GRANT, SETTLE, RD_REQ, RD_WAIT, WR_REQ, RETIRE.
//  IDLE: acts on inst_valid && one-hot decode.
//   - decode[3:0]: go to GRANT.
//   - decode[4] or [5]: latch src/dst/len, set idx=0, go to RD_REQ.
//   - STRNCPY with len==0: go directly to RETIRE; no memory access.
//   - invalid decode: err_decode pulse, remain IDLE.
//  GRANT: grant[op]=1 for exactly one cycle, then SETTLE.
//  SETTLE: one cycle for pc to update and decode to refresh, then IDLE.
//   - Throughput: 1 simple instr per 3 cycles.
//  RD_REQ: mem_req=1, we=0, addr=src+idx (wraps mod 2^ADDR_W).
//   - Request held stable until mem_gnt, then RD_WAIT.
//  RD_WAIT: on mem_rvalid capture rdata[7:0] into the byte register, then WR_REQ.
//   - mem_rvalid outside RD_WAIT is ignored.
//  WR_REQ: mem_req=1, we=1, addr=dst+idx (wraps), wdata={8'h00,byte}; held until mem_gnt.
//   - On mem_gnt, terminate if byte==0, or STRNCPY && idx+1==len, or STRCPY && idx+1==MAX_STR_LEN.
//   - Terminate -> RETIRE; otherwise idx++ -> RD_REQ.
//   - The NUL byte is always written.
//   - STRNCPY keeps copying past a 0 byte? No: it stops at 0 or at len, whichever is first.
//  RETIRE: grant[4] or [5] for one cycle (err_overrun with it if capped), then SETTLE.
//  Same-cycle mem_gnt and mem_rvalid cannot occur for one request; a new read is issued only after write accept.
//  decode/inst_valid are ignored while busy.
// CONFIGURATION
//  ACC_SEQ_PERF_EN defined: adds outputs perf_retired[31:0] and perf_str_cycles[31:0].
//   - perf_retired: +1 per grant pulse.
//   - perf_str_cycles: +1 per cycle in RD_REQ..RETIRE.
//   - Both saturate at 32'hFFFF_FFFF; async reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package acc_seq_pkg:
//   - state enum
//   - opcode index localparams OP_LOAD=0..OP_STRNCPY=5
//   - NUM_OPS=6
//   - function is_onehot6
//  Sub-module acc_str_engine: RD_REQ/RD_WAIT/WR_REQ loop, idx counter and termination test.
//   - start/done/overrun handshake to the top FSM.
//  The top level holds IDLE/GRANT/SETTLE/RETIRE and the grant encoding.
// TESTING
//  Simple instruction: decode=6'b000010, inst_valid=1
//   -> grant=6'b000010 exactly 1 cycle at cycle 1, busy 2 cycles, no mem_req.
//  STRCPY: src=0x10 holding 'A','B',0x00; dst=0x40; gnt/rvalid after 1 cycle each
//   -> 3 read/write pairs; mem 0x40..0x42 = 0x41,0x42,0x00; then grant[4] 1 cycle.
//  STRNCPY: len=2, src "XYZ\0"
//   -> writes only 0x58,0x59; grant[5]. len=0 -> grant[5] with no mem_req.
//  Wrap and backpressure: STRCPY src=0xFFFF, mem_gnt held low 5 cycles
//   -> addr/we/wdata stable while stalled; second read at addr 0x0000.
//  Errors: decode=6'b000011 -> err_decode pulse, no grant.
//   - STRCPY over 256 nonzero bytes -> 256 writes, grant[4] with err_overrun.
//  Async reset asserted in RD_WAIT -> mem_req=0, busy=0 immediately; no grant; late rvalid ignored.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the acc_multi instruction sequencer.
// State encoding, opcode bit positions and the one-hot decode check.
package acc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_WR_REQ  = 3'd5,
    ST_RETIRE  = 3'd6
  } state_t;

  localparam int unsigned NUM_OPS    = 6;
  localparam int unsigned OP_LOAD    = 0;
  localparam int unsigned OP_ADD     = 1;
  localparam int unsigned OP_STORE   = 2;
  localparam int unsigned OP_BRZ     = 3;
  localparam int unsigned OP_STRCPY  = 4;
  localparam int unsigned OP_STRNCPY = 5;

  localparam int unsigned LEN_W = 16;

  function automatic logic is_onehot6(input logic [NUM_OPS-1:0] v);
    return (v != '0) && ((v & (v - NUM_OPS'(1))) == '0);
  endfunction

endpackage

// File: rtl/acc_str_engine.sv
// String copy microsequencer: byte read/write loop on the shared req/gnt port.
// Signals done_c/overrun_c in the cycle the final write is accepted.
module acc_str_engine
  import acc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_STR_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_strn,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done_c,
  output logic              overrun_c
);

  localparam int unsigned CNT_W = LEN_W + 1;

  state_t              state, state_nx;
  logic [LEN_W-1:0]    idx, idx_nx;
  logic [7:0]          byte_q, byte_nx;
  logic [ADDR_W-1:0]   src_q, src_nx, dst_q, dst_nx;
  logic [LEN_W-1:0]    len_q, len_nx;
  logic                strn_q, strn_nx;
  logic                req_nx, we_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   wdata_nx;
  logic [CNT_W-1:0]    idx_p1;
  logic                cap_c, last_c;
  logic [DATA_W-9:0]   unused_rdata_hi;

  assign unused_rdata_hi = mem_rdata[DATA_W-1:8];

  // Termination test for the byte currently being written
  assign idx_p1 = CNT_W'(idx) + CNT_W'(1);
  assign cap_c  = !strn_q && (idx_p1 == CNT_W'(MAX_STR_LEN));
  assign last_c = (byte_q == 8'h00) || (strn_q && (idx_p1 == CNT_W'(len_q))) || cap_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      byte_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      strn_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      byte_q    <= byte_nx;
      src_q     <= src_nx;
      dst_q     <= dst_nx;
      len_q     <= len_nx;
      strn_q    <= strn_nx;
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    byte_nx   = byte_q;
    src_nx    = src_q;
    dst_nx    = dst_q;
    len_nx    = len_q;
    strn_nx   = strn_q;
    req_nx    = mem_req;
    we_nx     = mem_we;
    addr_nx   = mem_addr;
    wdata_nx  = mem_wdata;
    done_c    = 1'b0;
    overrun_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          src_nx   = src;
          dst_nx   = dst;
          len_nx   = len;
          strn_nx  = is_strn;
          idx_nx   = '0;
          req_nx   = 1'b1;
          we_nx    = 1'b0;
          addr_nx  = src;
          state_nx = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mem_gnt) begin
          req_nx   = 1'b0;
          state_nx = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          byte_nx  = mem_rdata[7:0];
          req_nx   = 1'b1;
          we_nx    = 1'b1;
          addr_nx  = dst_q + ADDR_W'(idx);
          wdata_nx = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
          state_nx = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (mem_gnt) begin
          req_nx = 1'b0;
          we_nx  = 1'b0;
          if (last_c) begin
            done_c    = 1'b1;
            overrun_c = cap_c && (byte_q != 8'h00);
            state_nx  = ST_IDLE;
          end else begin
            idx_nx   = LEN_W'(idx_p1);
            req_nx   = 1'b1;
            addr_nx  = src_q + ADDR_W'(idx_p1);
            state_nx = ST_RD_REQ;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/acc_multi_sequencer.sv
// Grant sequencer for the acc_multi datapath; string ops delegated to acc_str_engine.
// Optional perf counters enabled by defining ACC_SEQ_PERF_EN.
module acc_multi_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_STR_LEN = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_valid,
  input  logic [NUM_OPS-1:0] decode,
  input  logic [ADDR_W-1:0]  str_src,
  input  logic [ADDR_W-1:0]  str_dst,
  input  logic [LEN_W-1:0]   str_len,
  output logic [NUM_OPS-1:0] grant,
  output logic               busy,
  output logic               err_decode,
  output logic               err_overrun,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata
`ifdef ACC_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_str_cycles
`endif
);

  // ST_RD_REQ at this level means "string engine owns the sequence"
  state_t             state, state_nx;
  logic [NUM_OPS-1:0] op_q, op_nx, grant_nx;
  logic               busy_nx, err_decode_nx, err_overrun_nx;
  logic               start_c, done_c, overrun_c, simple_c;

  assign simple_c = decode[OP_LOAD] | decode[OP_ADD] | decode[OP_STORE] | decode[OP_BRZ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      err_decode  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nx;
      op_q        <= op_nx;
      grant       <= grant_nx;
      busy        <= busy_nx;
      err_decode  <= err_decode_nx;
      err_overrun <= err_overrun_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    op_nx          = op_q;
    grant_nx       = '0;
    err_decode_nx  = 1'b0;
    err_overrun_nx = 1'b0;
    start_c        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inst_valid) begin
          if (!is_onehot6(decode)) begin
            err_decode_nx = 1'b1;
          end else begin
            op_nx = decode;
            if (simple_c) begin
              grant_nx = decode;
              state_nx = ST_GRANT;
            end else if (decode[OP_STRNCPY] && (str_len == '0)) begin
              grant_nx = decode;
              state_nx = ST_RETIRE;
            end else begin
              start_c  = 1'b1;
              state_nx = ST_RD_REQ;
            end
          end
        end
      end
      ST_GRANT:  state_nx = ST_SETTLE;
      ST_RETIRE: state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_IDLE;
      ST_RD_REQ: begin
        if (done_c) begin
          grant_nx       = op_q;
          err_overrun_nx = overrun_c;
          state_nx       = ST_RETIRE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  acc_str_engine #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_STR_LEN (MAX_STR_LEN)
  ) u_str (
    .clk        (clk),
    .rst        (rst),
    .start      (start_c),
    .is_strn    (decode[OP_STRNCPY]),
    .src        (str_src),
    .dst        (str_dst),
    .len        (str_len),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .done_c     (done_c),
    .overrun_c  (overrun_c)
  );

`ifdef ACC_SEQ_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired    <= '0;
      perf_str_cycles <= '0;
    end else begin
      if ((grant != '0) && (perf_retired != 32'hFFFF_FFFF))
        perf_retired <= perf_retired + 32'd1;
      if (((state == ST_RD_REQ) || (state == ST_RETIRE)) && (perf_str_cycles != 32'hFFFF_FFFF))
        perf_str_cycles <= perf_str_cycles + 32'd1;
    end
  end
`endif

endmodule
